// File: rtl/hazard_stall_unit_if.sv
// ID-stage view for the hazard/stall unit: instruction fields in,
// stall controls and the stall counter out.
interface hazard_stall_unit_if #(
    parameter int CNT_W = 16
);
    logic             id_valid;
    logic             id_kill;
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic             id_uses_rs;
    logic             id_uses_rt;
    logic [4:0]       id_rd;
    logic             id_regwrite;
    logic             id_is_load;
    logic             id_is_mdu;
    logic             id_reads_hilo;
    logic             stall;
    logic             pc_write;
    logic             if_id_write;
    logic             id_ex_bubble;
    logic             mdu_busy;
    logic [CNT_W-1:0] stall_count;

    modport master (
        output id_valid, id_kill, id_rs, id_rt,
        output id_uses_rs, id_uses_rt, id_rd,
        output id_regwrite, id_is_load, id_is_mdu,
        output id_reads_hilo,
        input  stall, pc_write, if_id_write,
        input  id_ex_bubble, mdu_busy, stall_count
    );

    modport slave (
        input  id_valid, id_kill, id_rs, id_rt,
        input  id_uses_rs, id_uses_rt, id_rd,
        input  id_regwrite, id_is_load, id_is_mdu,
        input  id_reads_hilo,
        output stall, pc_write, if_id_write,
        output id_ex_bubble, mdu_busy, stall_count
    );
endinterface

// File: rtl/hazard_stall_unit.sv
// Load-use and HI/LO-vs-MDU hazard detection between ID and EX,
// with PC/IF-ID freeze, ID/EX bubble and a saturating stall counter.
module hazard_stall_unit #(
    parameter int MDU_LATENCY = 4,
    parameter int CNT_W       = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    hazard_stall_unit_if.slave   bus
);
    logic             ex_load;
    logic [4:0]       ex_rd;
    logic [3:0]       mdu_cnt;
    logic [CNT_W-1:0] cnt;

    logic v;
    logic issue;
    logic rs_hit;
    logic rt_hit;
    logic lu;
    logic mh;
    logic busy;
    logic stall;

    assign v      = bus.id_valid & ~bus.id_kill;
    assign busy   = (mdu_cnt != 4'd0);
    assign rs_hit = bus.id_uses_rs & (bus.id_rs == ex_rd);
    assign rt_hit = bus.id_uses_rt & (bus.id_rt == ex_rd);
    assign lu     = v & ex_load & (ex_rd != 5'd0) & (rs_hit | rt_hit);
    assign mh     = v & busy & (bus.id_reads_hilo | bus.id_is_mdu);
    assign stall  = lu | mh;
    assign issue  = v & ~stall;

    assign bus.stall        = stall;
    assign bus.pc_write     = ~stall;
    assign bus.if_id_write  = ~stall;
    assign bus.id_ex_bubble = stall;
    assign bus.mdu_busy     = busy;
    assign bus.stall_count  = cnt;

    // A stalled or empty slot enters EX as a bubble, so ex_load drops.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_load <= 1'b0;
            ex_rd   <= 5'd0;
        end else if (issue) begin
            ex_load <= bus.id_is_load & bus.id_regwrite;
            ex_rd   <= bus.id_rd;
        end else begin
            ex_load <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mdu_cnt <= 4'd0;
        end else if (issue && bus.id_is_mdu) begin
            mdu_cnt <= 4'(MDU_LATENCY);
        end else if (busy) begin
            mdu_cnt <= mdu_cnt - 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (stall && (cnt != {CNT_W{1'b1}})) begin
            cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed checks for hazard_stall_unit: load-use, $0/ALU writers,
// MDU countdown, kill, reset mid-MDU and counter saturation.
module tb_hazard_stall_unit;
    localparam int CNT_W = 4;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    hazard_stall_unit_if #(.CNT_W(CNT_W)) bus ();

    hazard_stall_unit #(
        .MDU_LATENCY(4),
        .CNT_W      (CNT_W)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.id_valid      = 1'b0;
        bus.id_kill       = 1'b0;
        bus.id_rs         = 5'd0;
        bus.id_rt         = 5'd0;
        bus.id_uses_rs    = 1'b0;
        bus.id_uses_rt    = 1'b0;
        bus.id_rd         = 5'd0;
        bus.id_regwrite   = 1'b0;
        bus.id_is_load    = 1'b0;
        bus.id_is_mdu     = 1'b0;
        bus.id_reads_hilo = 1'b0;
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic load(input logic [4:0] rd);
        idle();
        bus.id_valid    = 1'b1;
        bus.id_rd       = rd;
        bus.id_regwrite = 1'b1;
        bus.id_is_load  = 1'b1;
        #1;
    endtask

    task automatic alu(input logic [4:0] rs, input logic [4:0] rt,
                       input logic urs, input logic urt,
                       input logic [4:0] rd);
        idle();
        bus.id_valid    = 1'b1;
        bus.id_rs       = rs;
        bus.id_rt       = rt;
        bus.id_uses_rs  = urs;
        bus.id_uses_rt  = urt;
        bus.id_rd       = rd;
        bus.id_regwrite = 1'b1;
        #1;
    endtask

    task automatic mult();
        idle();
        bus.id_valid  = 1'b1;
        bus.id_is_mdu = 1'b1;
        #1;
    endtask

    task automatic mflo();
        idle();
        bus.id_valid      = 1'b1;
        bus.id_reads_hilo = 1'b1;
        bus.id_rd         = 5'd8;
        bus.id_regwrite   = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        load(5'd5);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        alu(5'd5, 5'd5, 1'b1, 1'b1, 5'd6);
        checks++;
        if (bus.stall !== 1'b0 || bus.pc_write !== 1'b1 ||
            bus.if_id_write !== 1'b1 || bus.id_ex_bubble !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctl got st=%b pcw=%b ifw=%b bub=%b want 0110",
                     bus.stall, bus.pc_write, bus.if_id_write, bus.id_ex_bubble);
        end
        checks++;
        if (bus.mdu_busy !== 1'b0 || bus.stall_count !== 4'd0) begin
            errors++;
            $display("FAIL reset_state got busy=%b cnt=%0d want 0 0",
                     bus.mdu_busy, bus.stall_count);
        end
    endtask

    task automatic test_load_use();
        do_reset();
        load(5'd5);
        checks++;
        if (bus.stall !== 1'b0) begin
            errors++;
            $display("FAIL lu_lw_issue got stall=%b want 0", bus.stall);
        end
        tick();
        alu(5'd5, 5'd2, 1'b1, 1'b0, 5'd6);
        checks++;
        if (bus.stall !== 1'b1 || bus.id_ex_bubble !== 1'b1 ||
            bus.pc_write !== 1'b0 || bus.if_id_write !== 1'b0) begin
            errors++;
            $display("FAIL lu_rs_stall got st=%b bub=%b pcw=%b ifw=%b want 1100",
                     bus.stall, bus.id_ex_bubble, bus.pc_write, bus.if_id_write);
        end
        tick();
        checks++;
        if (bus.stall !== 1'b0 || bus.stall_count !== 4'd1) begin
            errors++;
            $display("FAIL lu_rs_release got stall=%b cnt=%0d want 0 1",
                     bus.stall, bus.stall_count);
        end
        tick();
        load(5'd9);
        tick();
        alu(5'd9, 5'd9, 1'b0, 1'b0, 5'd3);
        checks++;
        if (bus.stall !== 1'b0) begin
            errors++;
            $display("FAIL lu_unused got stall=%b want 0", bus.stall);
        end
        alu(5'd1, 5'd9, 1'b0, 1'b1, 5'd3);
        checks++;
        if (bus.stall !== 1'b1) begin
            errors++;
            $display("FAIL lu_rt_stall got stall=%b want 1", bus.stall);
        end
        tick();
        checks++;
        if (bus.stall !== 1'b0 || bus.stall_count !== 4'd2) begin
            errors++;
            $display("FAIL lu_rt_release got stall=%b cnt=%0d want 0 2",
                     bus.stall, bus.stall_count);
        end
        idle();
    endtask

    task automatic test_no_stall();
        do_reset();
        load(5'd0);
        tick();
        alu(5'd0, 5'd0, 1'b1, 1'b1, 5'd4);
        checks++;
        if (bus.stall !== 1'b0) begin
            errors++;
            $display("FAIL load_r0 got stall=%b want 0", bus.stall);
        end
        tick();
        alu(5'd1, 5'd2, 1'b1, 1'b1, 5'd7);
        tick();
        alu(5'd7, 5'd7, 1'b1, 1'b1, 5'd8);
        checks++;
        if (bus.stall !== 1'b0 || bus.stall_count !== 4'd0) begin
            errors++;
            $display("FAIL alu_writer got stall=%b cnt=%0d want 0 0",
                     bus.stall, bus.stall_count);
        end
        idle();
    endtask

    task automatic test_mdu();
        do_reset();
        mult();
        checks++;
        if (bus.stall !== 1'b0 || bus.mdu_busy !== 1'b0) begin
            errors++;
            $display("FAIL mdu_issue got stall=%b busy=%b want 0 0",
                     bus.stall, bus.mdu_busy);
        end
        tick();
        mflo();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (bus.stall !== 1'b1 || bus.mdu_busy !== 1'b1) begin
                errors++;
                $display("FAIL mdu_wait%0d got stall=%b busy=%b want 1 1",
                         i, bus.stall, bus.mdu_busy);
            end
            tick();
        end
        checks++;
        if (bus.stall !== 1'b0 || bus.mdu_busy !== 1'b0 ||
            bus.stall_count !== 4'd4) begin
            errors++;
            $display("FAIL mdu_release got stall=%b busy=%b cnt=%0d want 0 0 4",
                     bus.stall, bus.mdu_busy, bus.stall_count);
        end
        idle();
    endtask

    task automatic test_kill();
        do_reset();
        load(5'd5);
        tick();
        alu(5'd5, 5'd0, 1'b1, 1'b0, 5'd6);
        bus.id_kill = 1'b1;
        #1;
        checks++;
        if (bus.stall !== 1'b0 || bus.id_ex_bubble !== 1'b0) begin
            errors++;
            $display("FAIL kill_drop got stall=%b bub=%b want 0 0",
                     bus.stall, bus.id_ex_bubble);
        end
        tick();
        alu(5'd5, 5'd0, 1'b1, 1'b0, 5'd6);
        checks++;
        if (bus.stall !== 1'b0 || bus.stall_count !== 4'd0) begin
            errors++;
            $display("FAIL kill_cleared got stall=%b cnt=%0d want 0 0",
                     bus.stall, bus.stall_count);
        end
        idle();
    endtask

    task automatic test_reset_mid_mdu();
        do_reset();
        mult();
        tick();
        idle();
        tick();
        mflo();
        checks++;
        if (bus.stall !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_stall got stall=%b want 1", bus.stall);
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
        checks++;
        if (bus.mdu_busy !== 1'b0 || bus.stall !== 1'b0 ||
            bus.stall_count !== 4'd0) begin
            errors++;
            $display("FAIL reset_mid_mdu got busy=%b stall=%b cnt=%0d want 0 0 0",
                     bus.mdu_busy, bus.stall, bus.stall_count);
        end
        idle();
    endtask

    task automatic test_saturation();
        do_reset();
        mult();
        for (int i = 0; i < 10; i++) tick();
        checks++;
        if (bus.stall_count !== 4'd8) begin
            errors++;
            $display("FAIL sat_mid got cnt=%0d want 8", bus.stall_count);
        end
        for (int i = 0; i < 20; i++) tick();
        checks++;
        if (bus.stall_count !== 4'd15) begin
            errors++;
            $display("FAIL sat_hold got cnt=%0d want 15", bus.stall_count);
        end
        for (int i = 0; i < 6; i++) tick();
        checks++;
        if (bus.stall_count !== 4'd15) begin
            errors++;
            $display("FAIL sat_nowrap got cnt=%0d want 15", bus.stall_count);
        end
        idle();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        idle();
        tick();
        test_reset();
        test_load_use();
        test_no_stall();
        test_mdu();
        test_kill();
        test_reset_mid_mdu();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
